tdm_demultiplexer: RTL and testbench
====================================

Name: tdm_demultiplexer

Overview:
1-to-4 time-division demultiplexer. It is the receive-side counterpart of the team's 4:1 multiplexer with 2-bit select C.
- Accepts a framed serial stream of WIDTH-bit slots.
- Routes slot i into output lane i.
- Presents all four lanes atomically, with a one-cycle frame_valid strobe, once a complete frame has arrived.
- Sits between a TDM link (fed by the mux-side framer) and per-channel consumers.

Parameters:
WIDTH, 4, bits per slot and per output lane.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
sof  input  1  start-of-frame; qualified by in_valid; marks slot 0
in_valid  input  1  din carries a valid slot this cycle
din  input  WIDTH  slot data
Y  output  4*WIDTH  committed frame; lane i = Y[i*WIDTH +: WIDTH]
C  output  2  index of next expected slot (0 when idle)
frame_valid  output  1  one-cycle pulse; Y updated this cycle
frame_err  output  1  one-cycle pulse; frame discarded
busy  output  1  frame in progress

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. Reset is sampled only on the clk rising edge.
- Reset values: Y=0, C=0, frame_valid=0, frame_err=0, busy=0, state IDLE, slot counter 0, shadow lanes 0.
- States are IDLE and RECV (plus PAR with the optional feature).
- All outputs are registered.
- In IDLE:
  - in_valid & sof: din goes to shadow lane 0, counter=1, go to RECV.
  - in_valid without sof: ignored.
- In RECV, on in_valid & !sof:
  - din goes to shadow lane[counter], and the counter increments.
  - When counter==3: commit all four shadow lanes to Y, pulse frame_valid, go to IDLE.
- Cycles without in_valid: no change. C and the shadow lanes hold; there is no timeout.
- Early sof in RECV (in_valid & sof before slot 3): frame_err pulses on the following cycle, the partial frame is discarded, din goes to shadow lane 0, counter=1, state stays RECV.
- Latency: Y and frame_valid update on the edge that samples slot 3, so they are visible in the next cycle.
- Back-to-back frames: sof is accepted in the cycle immediately after the last slot. Full throughput is 1 slot per cycle.
- Y changes only at commit. A partial frame never alters Y.
- C = counter in RECV, 0 in IDLE.
- busy = (state != IDLE).
- frame_valid and frame_err are never asserted in the same cycle.
- Reset mid-frame: the partial frame is lost and all outputs return to their reset values on the next edge.

Optional Feature:
Macro: TDM_PARITY_EN.
- Defined:
  - A fifth parity slot follows slot 3; the transition after slot 3 goes to PAR instead of committing.
  - In PAR, on in_valid & !sof: if din[0] equals the XOR-reduce of all 4*WIDTH shadow bits, commit Y and pulse frame_valid. Otherwise pulse frame_err and leave Y unchanged. Go to IDLE in both cases.
  - sof in PAR is handled as an early sof.
  - C reads 0 during PAR; busy=1.
- Undefined:
  - No PAR state; commit occurs on slot 3.
  - frame_err signals early-sof only.

Test Plan:
1. Reset (WIDTH=4): hold reset_n=0 for 2 edges with random sof/in_valid/din -> Y=0x0000, C=0, busy=0, frame_valid=0, frame_err=0.
2. Contiguous frame: (sof,1),2,3,4 on 4 consecutive cycles -> C counts 1,2,3 then 0; next cycle Y=0x4321 with frame_valid=1 for exactly one cycle.
3. Gapped frame: same slots with 2 idle cycles between each -> C holds during gaps, Y stays at its old value until commit, then Y=0x4321 and one frame_valid pulse. Also check back-to-back sof on the next cycle is accepted.
4. Resync: (sof,A),B then (sof,5),6,7,8 -> frame_err pulse after the second sof, Y unchanged until final commit, then Y=0x8765, frame_valid once.
5. Reset mid-frame: (sof,9),A then reset_n=0 for 1 edge, then (sof,1),2,3,4 -> Y=0 and busy=0 after reset, final Y=0x4321.
6. TDM_PARITY_EN: slots 1,2,3,4 then parity din=0x1 -> Y=0x4321 with frame_valid; repeat with slots 5,6,7,8 and parity din=0x1 (expected 0) -> frame_err, Y remains 0x4321.

Source files
------------

// File: rtl/tdm_demultiplexer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tdm_demultiplexer: 1-to-4 TDM slot demultiplexer with atomic frame commit |
// | Optional parity slot when TDM_PARITY_EN is defined.  Rev 1.0              |
// +--------------------------------------------------------------------------+
module tdm_demultiplexer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sof,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     din,
    output logic [4*WIDTH-1:0]   Y,
    output logic [1:0]           C,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_nxt;
    logic [4*WIDTH-1:0]   r_shadow;
    logic [4*WIDTH-1:0]   w_shadow_nxt;
    logic [4*WIDTH-1:0]   w_y_nxt;
    logic [1:0]           w_c_nxt;
    logic                 w_fv_nxt;
    logic                 w_fe_nxt;
    logic                 w_busy_nxt;
    logic                 w_start;
    logic                 w_accept;

    assign w_start  = in_valid & sof;
    assign w_accept = in_valid & ~sof;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_shadow    <= '0;
            Y           <= '0;
            C           <= 2'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            Y           <= w_y_nxt;
            C           <= w_c_nxt;
            frame_valid <= w_fv_nxt;
            frame_err   <= w_fe_nxt;
            busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_y_nxt      = Y;
        w_fv_nxt     = 1'b0;
        w_fe_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_shadow_nxt[WIDTH-1:0] = din;
                    w_cnt_nxt               = 2'd1;
                    w_state_nxt             = S_RECV;
                end
            end
            S_RECV: begin
                if (w_start) begin
                    // Resync: drop the partial frame and restart at slot 0
                    w_fe_nxt                = 1'b1;
                    w_shadow_nxt[WIDTH-1:0] = din;
                    w_cnt_nxt               = 2'd1;
                end else if (w_accept) begin
                    w_shadow_nxt[r_cnt*WIDTH +: WIDTH] = din;
                    if (r_cnt == 2'd3) begin
                        w_cnt_nxt   = 2'd0;
`ifdef TDM_PARITY_EN
                        w_state_nxt = S_PAR;
`else
                        w_y_nxt     = {din, r_shadow[3*WIDTH-1:0]};
                        w_fv_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end
`ifdef TDM_PARITY_EN
            S_PAR: begin
                if (w_start) begin
                    w_fe_nxt                = 1'b1;
                    w_shadow_nxt[WIDTH-1:0] = din;
                    w_cnt_nxt               = 2'd1;
                    w_state_nxt             = S_RECV;
                end else if (w_accept) begin
                    if (din[0] == ^r_shadow) begin
                        w_y_nxt  = r_shadow;
                        w_fv_nxt = 1'b1;
                    end else begin
                        w_fe_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase

        w_c_nxt    = (w_state_nxt == S_RECV) ? w_cnt_nxt : 2'd0;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demultiplexer.sv
`default_nettype none
// Testbench for tdm_demultiplexer: directed plan plus random traffic,
// checked by a frame-level reference model through a scoreboard.
module tb_tdm_demultiplexer;

    localparam int WIDTH = 4;
`ifdef TDM_PARITY_EN
    localparam int NSLOT = 5;
`else
    localparam int NSLOT = 4;
`endif

    logic                clk;
    logic                reset_n;
    logic                sof;
    logic                in_valid;
    logic [WIDTH-1:0]    din;
    logic [4*WIDTH-1:0]  Y;
    logic [1:0]          C;
    logic                frame_valid;
    logic                frame_err;
    logic                busy;

    tdm_demultiplexer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sof         (sof),
        .in_valid    (in_valid),
        .din         (din),
        .Y           (Y),
        .C           (C),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [1:0]  c;
        logic        busy;
        logic        fv;
        logic        fe;
    } cyc_t;

    typedef struct {
        logic        is_err;
        logic [15:0] y;
    } evt_t;

    cyc_t cyc_q[$];
    evt_t evt_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: slots collected so far and last committed frame
    logic [3:0]  slots[$];
    logic [15:0] m_y = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit s, input bit v, input logic [3:0] d, input bit rn);
        cyc_t        e;
        evt_t        ev;
        logic [15:0] frame;
        int          ones;
        bit          ok;
        @(negedge clk);
        sof = s; in_valid = v; din = d; reset_n = rn;
        e.fv = 1'b0;
        e.fe = 1'b0;
        if (!rn) begin
            slots.delete();
            m_y = 16'h0;
        end else if (v) begin
            if (s) begin
                if (slots.size() > 0) begin
                    e.fe = 1'b1;
                    ev.is_err = 1'b1; ev.y = m_y;
                    evt_q.push_back(ev);
                end
                slots.delete();
                slots.push_back(d);
            end else if (slots.size() > 0) begin
                slots.push_back(d);
                if (slots.size() == NSLOT) begin
                    frame = 16'h0;
                    ones  = 0;
                    for (int i = 0; i < 4; i++) begin
                        frame = frame | (16'(slots[i]) << (4 * i));
                        ones  = ones + $countones(slots[i]);
                    end
                    ok = 1'b1;
`ifdef TDM_PARITY_EN
                    ok = (slots[4][0] == ones[0]);
`endif
                    if (ok) begin
                        m_y  = frame;
                        e.fv = 1'b1;
                    end else begin
                        e.fe = 1'b1;
                    end
                    ev.is_err = !ok; ev.y = m_y;
                    evt_q.push_back(ev);
                    slots.delete();
                end
            end
        end
        e.y    = m_y;
        e.c    = (slots.size() >= 1 && slots.size() <= 3) ? 2'(slots.size()) : 2'd0;
        e.busy = (slots.size() > 0);
        cyc_q.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'($urandom), 1'b0, 4'($urandom), 1'b1);
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input int g);
        step(1'b1, 1'b1, a, 1'b1); gap(g);
        step(1'b0, 1'b1, b, 1'b1); gap(g);
        step(1'b0, 1'b1, c, 1'b1); gap(g);
        step(1'b0, 1'b1, d, 1'b1);
`ifdef TDM_PARITY_EN
        gap(g);
        step(1'b0, 1'b1, {3'b000, ^{a, b, c, d}}, 1'b1);
`endif
    endtask

    // Monitor: per-cycle state check plus event scoreboard on each pulse
    initial begin
        cyc_t e;
        evt_t ev;
        forever begin
            @(posedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("Y", 32'(Y), 32'(e.y));
                check("C", 32'(C), 32'(e.c));
                check("busy", 32'(busy), 32'(e.busy));
                check("frame_valid", 32'(frame_valid), 32'(e.fv));
                check("frame_err", 32'(frame_err), 32'(e.fe));
            end
            if (frame_valid === 1'b1 || frame_err === 1'b1) begin
                if (evt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got fv=%0b fe=%0b expected none", frame_valid, frame_err);
                end else begin
                    ev = evt_q.pop_front();
                    check("event_kind_err", 32'(frame_err), 32'(ev.is_err));
                    check("event_Y", 32'(Y), 32'(ev.y));
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; sof = 1'b0; in_valid = 1'b0; din = '0;
        // Reset with random inputs
        repeat (2) step(1'($urandom), 1'($urandom), 4'($urandom), 1'b0);
        // Contiguous frame
        send_frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
        gap(1);
        // Gapped frame, then back-to-back frame
        send_frame(4'h1, 4'h2, 4'h3, 4'h4, 2);
        send_frame(4'h9, 4'hA, 4'hB, 4'hC, 0);
        gap(1);
        // Resync on early sof
        step(1'b1, 1'b1, 4'hA, 1'b1);
        step(1'b0, 1'b1, 4'hB, 1'b1);
        send_frame(4'h5, 4'h6, 4'h7, 4'h8, 0);
        gap(1);
        // Reset mid-frame
        step(1'b1, 1'b1, 4'h9, 1'b1);
        step(1'b0, 1'b1, 4'hA, 1'b1);
        step(1'($urandom), 1'($urandom), 4'($urandom), 1'b0);
        send_frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
        gap(1);
`ifdef TDM_PARITY_EN
        // Deliberately wrong parity: frame must be rejected
        step(1'b1, 1'b1, 4'h5, 1'b1);
        step(1'b0, 1'b1, 4'h6, 1'b1);
        step(1'b0, 1'b1, 4'h7, 1'b1);
        step(1'b0, 1'b1, 4'h8, 1'b1);
        step(1'b0, 1'b1, 4'h1, 1'b1);
        gap(1);
`endif
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 10) < 7, 4'($urandom),
                 ($urandom % 60) != 0);
        end
        gap(3);
        @(negedge clk);
        check("pending_events", 32'(evt_q.size()), 32'd0);
        check("pending_cycles", 32'(cyc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
